// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response, fetch->decode buffer, execute redirect.
// Latency: n/a (wires only).
// Backpressure: id_ready throttles the fetch buffer; imem_gnt throttles requests.
// Ports (master = fetch_unit):
//   out: imem_req, imem_addr, if_valid, if_instr, if_pc, flush
//   in : imem_gnt, imem_rvalid, imem_rdata, id_ready, ex_valid, take_branch, branch_target
interface fetch_unit_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) ();
  logic               ex_valid;
  logic               take_branch;
  logic [PC_W-1:0]    branch_target;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               id_ready;
  logic               flush;

  modport master (
    input  ex_valid, take_branch, branch_target,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid, if_instr, if_pc,
    input  id_ready,
    output flush
  );

  modport slave (
    output ex_valid, take_branch, branch_target,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid, if_instr, if_pc,
    output id_ready,
    input  flush
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: holds PC, issues one imem read at a time, buffers one instruction.
// Latency: rvalid edge -> if_valid; zero-wait memory gives 1 instruction per 2 cycles.
// Backpressure: a new read issues only when the buffer is empty or draining (id_ready).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_unit_if.master (imem req/gnt/rvalid, if_* buffer, redirect, flush)
module fetch_unit #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    issued_pc_q, issued_pc_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic               flush_q, flush_d;

  logic redirect;
  logic req;
  logic fire;

  assign redirect = bus.ex_valid & bus.take_branch;
  // Issuing while the buffer drains keeps the single-outstanding invariant:
  // the response can never land on a full buffer.
  assign req      = !rst && (state_q == S_REQ) && (!if_valid_q || bus.id_ready);
  assign fire     = req & bus.imem_gnt;

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.flush     = flush_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issued_pc_d = issued_pc_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    flush_d     = 1'b0;

    if (if_valid_q && bus.id_ready) begin
      if_valid_d = 1'b0;
    end

    unique case (state_q)
      S_REQ: begin
        if (fire) begin
          issued_pc_d = pc_q;
          pc_d        = pc_q + PC_W'(1);
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          if_instr_d = bus.imem_rdata;
          if_pc_d    = issued_pc_q;
          if_valid_d = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (bus.imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect wins over everything: new PC, empty buffer, and any read that
    // is granted or still in flight becomes stale and must be dropped.
    if (redirect) begin
      pc_d       = bus.branch_target;
      if_valid_d = 1'b0;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      flush_d    = 1'b1;
      unique case (state_q)
        S_REQ:   state_d = fire ? S_DROP : S_REQ;
        S_WAIT,
        S_DROP:  state_d = bus.imem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      issued_pc_q <= '0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issued_pc_q <= issued_pc_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      flush_q     <= flush_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall, redirects, PC wrap.
// Latency: n/a.
// Backpressure: driven directly through id_ready / imem_gnt vectors.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  logic rst2;

  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(16), .INSTR_W(16)) m1 ();
  fetch_unit_if #(.PC_W(16), .INSTR_W(16)) m2 ();

  fetch_unit #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m1.master)
  );

  fetch_unit #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'hFFFF)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (m2.master)
  );

  int n_vec = 0;
  int n_err = 0;

  // Memory model state for m1: one outstanding read, response after lat cycles.
  logic        pend  = 1'b0;
  int          pcnt  = 0;
  int          lat   = 1;
  logic [15:0] paddr = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: sample the m1 handshake before the edge, then update the
  // memory response 1 time unit after the edge.
  task automatic cyc();
    logic        fire;
    logic [15:0] a;
    #1;
    fire = m1.imem_req && m1.imem_gnt;
    a    = m1.imem_addr;
    @(posedge clk);
    #1;
    m1.imem_rvalid = 1'b0;
    if (fire) begin
      pend  = 1'b1;
      pcnt  = lat;
      paddr = a;
    end
    if (pend) begin
      if (pcnt <= 1) begin
        m1.imem_rvalid = 1'b1;
        m1.imem_rdata  = paddr ^ 16'hA5A5;
        pend           = 1'b0;
      end else begin
        pcnt = pcnt - 1;
      end
    end
  endtask

  task automatic branch(input logic ev, input logic tb_, input logic [15:0] tgt);
    m1.ex_valid      = ev;
    m1.take_branch   = tb_;
    m1.branch_target = tgt;
  endtask

  initial begin
    rst  = 1'b1;
    rst2 = 1'b1;
    m1.ex_valid = 0; m1.take_branch = 0; m1.branch_target = '0;
    m1.imem_gnt = 0; m1.imem_rvalid = 0; m1.imem_rdata = '0; m1.id_ready = 0;
    m2.ex_valid = 0; m2.take_branch = 0; m2.branch_target = '0;
    m2.imem_gnt = 0; m2.imem_rvalid = 0; m2.imem_rdata = '0; m2.id_ready = 0;

    // 1: reset
    cyc();
    cyc();
    chk("rst_req",      32'(m1.imem_req), 32'd0);
    chk("rst_if_valid", 32'(m1.if_valid), 32'd0);
    chk("rst_if_instr", 32'(m1.if_instr), 32'h0);
    chk("rst_if_pc",    32'(m1.if_pc),    32'h0);
    chk("rst_flush",    32'(m1.flush),    32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req",  32'(m1.imem_req),  32'd1);
    chk("post_rst_addr", 32'(m1.imem_addr), 32'h0);

    // 2: zero-wait streaming
    m1.imem_gnt = 1'b1;
    m1.id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("strm_gap_valid", 32'(m1.if_valid), 32'd0);
      cyc();
      chk("strm_valid", 32'(m1.if_valid), 32'd1);
      chk("strm_pc",    32'(m1.if_pc),    32'(i));
      chk("strm_instr", 32'(m1.if_instr), 32'(16'(i) ^ 16'hA5A5));
    end

    // 3: decode stall holds the buffer and blocks requests
    m1.id_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req",   32'(m1.imem_req), 32'd0);
      chk("stall_pc",    32'(m1.if_pc),    32'h3);
      chk("stall_instr", 32'(m1.if_instr), 32'hA5A6);
      chk("stall_valid", 32'(m1.if_valid), 32'd1);
      cyc();
    end
    m1.id_ready = 1'b1;
    #1;
    chk("release_req",  32'(m1.imem_req),  32'd1);
    chk("release_addr", 32'(m1.imem_addr), 32'h4);
    cyc();
    cyc();
    chk("after_stall_pc", 32'(m1.if_pc), 32'h4);

    // 4: redirect while waiting for addr 5
    lat = 3;
    chk("pre4_addr", 32'(m1.imem_addr), 32'h5);
    cyc();
    branch(1'b1, 1'b1, 16'h0040);
    #1;
    chk("wait_req", 32'(m1.imem_req), 32'd0);
    cyc();
    branch(1'b0, 1'b0, 16'h0000);
    chk("r4_flush",    32'(m1.flush),    32'd1);
    chk("r4_if_valid", 32'(m1.if_valid), 32'd0);
    chk("r4_drop_req", 32'(m1.imem_req), 32'd0);
    cyc();
    chk("r4_flush_off", 32'(m1.flush), 32'd0);
    cyc();
    chk("r4_dropped", 32'(m1.if_valid),  32'd0);
    chk("r4_req",     32'(m1.imem_req),  32'd1);
    chk("r4_addr",    32'(m1.imem_addr), 32'h0040);
    lat = 1;
    cyc();
    cyc();
    chk("r4_pc",    32'(m1.if_pc),    32'h0040);
    chk("r4_instr", 32'(m1.if_instr), 32'hA5E5);

    // 5a: redirect in REQ with no grant; overrides the buffer accept
    m1.imem_gnt = 1'b0;
    branch(1'b1, 1'b1, 16'h0008);
    cyc();
    branch(1'b0, 1'b0, 16'h0000);
    chk("r5a_valid", 32'(m1.if_valid),  32'd0);
    chk("r5a_flush", 32'(m1.flush),     32'd1);
    chk("r5a_addr",  32'(m1.imem_addr), 32'h0008);

    // 5b: redirect coincident with grant at addr 8
    m1.imem_gnt = 1'b1;
    branch(1'b1, 1'b1, 16'h0100);
    cyc();
    branch(1'b0, 1'b0, 16'h0000);
    chk("r5b_flush", 32'(m1.flush),    32'd1);
    chk("r5b_req",   32'(m1.imem_req), 32'd0);
    cyc();
    chk("r5b_valid",     32'(m1.if_valid),  32'd0);
    chk("r5b_flush_off", 32'(m1.flush),     32'd0);
    chk("r5b_addr",      32'(m1.imem_addr), 32'h0100);

    // 5c: redirect coincident with rvalid
    cyc();
    branch(1'b1, 1'b1, 16'h0200);
    cyc();
    chk("r5c_valid", 32'(m1.if_valid),  32'd0);
    chk("r5c_flush", 32'(m1.flush),     32'd1);
    chk("r5c_addr",  32'(m1.imem_addr), 32'h0200);

    // 5d: take_branch without ex_valid is ignored
    branch(1'b0, 1'b1, 16'h0300);
    cyc();
    chk("r5d_flush", 32'(m1.flush), 32'd0);
    cyc();
    chk("r5d_pc",    32'(m1.if_pc),     32'h0200);
    chk("r5d_instr", 32'(m1.if_instr),  32'hA7A5);
    chk("r5d_addr",  32'(m1.imem_addr), 32'h0201);
    branch(1'b0, 1'b0, 16'h0000);

    // 6: RESET_PC=FFFF wrap, then reset while waiting
    rst2 = 1'b0;
    m2.imem_gnt = 1'b1;
    m2.id_ready = 1'b1;
    #1;
    chk("w_req",  32'(m2.imem_req),  32'd1);
    chk("w_addr", 32'(m2.imem_addr), 32'hFFFF);
    cyc();
    m2.imem_rvalid = 1'b1;
    m2.imem_rdata  = 16'h1234;
    cyc();
    m2.imem_rvalid = 1'b0;
    chk("w_pc_ffff", 32'(m2.if_pc),     32'hFFFF);
    chk("w_instr",   32'(m2.if_instr),  32'h1234);
    chk("w_addr0",   32'(m2.imem_addr), 32'h0000);
    cyc();
    m2.imem_rvalid = 1'b1;
    m2.imem_rdata  = 16'h5678;
    cyc();
    m2.imem_rvalid = 1'b0;
    chk("w_pc_0000", 32'(m2.if_pc),  32'h0000);
    chk("w_valid",   32'(m2.if_valid), 32'd1);
    cyc();
    chk("w_wait_req", 32'(m2.imem_req), 32'd0);
    rst2 = 1'b1;
    cyc();
    chk("w_rst_valid", 32'(m2.if_valid), 32'd0);
    chk("w_rst_req",   32'(m2.imem_req), 32'd0);
    rst2 = 1'b0;
    #1;
    chk("w_rel_req",  32'(m2.imem_req),  32'd1);
    chk("w_rel_addr", 32'(m2.imem_addr), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
